// File: rtl/mul_pkg.sv
// Shared definitions for the long multiply unit: op encodings, FSM states, default width.
package mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL   = 3'b000,
        OP_MLA   = 3'b001,
        OP_UMULL = 3'b100,
        OP_UMLAL = 3'b101,
        OP_SMULL = 3'b110,
        OP_SMLAL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Long ops produce a 2*WIDTH result; 010/011 fall through to plain MUL.
    function automatic logic op_is_long(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_has_acc(input logic [2:0] op);
        return op[2] ? op[0] : (op == OP_MLA);
    endfunction

endpackage

// File: rtl/mul_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and product sign fixup.
module mul_negate #(
    parameter int unsigned W = 64
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/long_mul_unit.sv
// Iterative shift-add multiplier with optional accumulate, short and long (2*WIDTH) results.
module long_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] AccLo,
    input  logic [WIDTH-1:0] AccHi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e           state;
    logic [2:0]       op_q;
    logic             sign_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [PW-1:0]    prod_q;
    logic [CW-1:0]    count_q;

    logic             neg_in_a;
    logic             neg_in_b;
    logic [PW-1:0]    mag_a;
    logic [PW-1:0]    mag_b;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH:0]   step_sum;
    logic [PW-1:0]    prod_step;
    logic [PW-1:0]    acc_ext;
    logic [PW-1:0]    result_c;
    logic             long_q_c;
    logic             unused_mag_hi;

    assign neg_in_a = op_is_signed(op) & SrcA[WIDTH-1];
    assign neg_in_b = op_is_signed(op) & SrcB[WIDTH-1];

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits the unsigned W-bit operand.
    mul_negate #(.W(PW)) u_neg_a (
        .en   (neg_in_a),
        .din  ({{WIDTH{SrcA[WIDTH-1]}}, SrcA}),
        .dout (mag_a)
    );

    mul_negate #(.W(PW)) u_neg_b (
        .en   (neg_in_b),
        .din  ({{WIDTH{SrcB[WIDTH-1]}}, SrcB}),
        .dout (mag_b)
    );

    mul_negate #(.W(PW)) u_neg_prod (
        .en   (sign_q),
        .din  (prod_q),
        .dout (prod_fix)
    );

    assign unused_mag_hi = ^{mag_a[PW-1:WIDTH], mag_b[PW-1:WIDTH]};

    // Right-shifting accumulator: add multiplicand into the upper half, then shift one bit.
    assign step_sum  = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

    assign long_q_c = op_is_long(op_q);

    always_comb begin
        acc_ext = '0;
        if (op_has_acc(op_q)) begin
            acc_ext = long_q_c ? {acc_hi_q, acc_lo_q} : {{WIDTH{1'b0}}, acc_lo_q};
        end
        result_c = prod_fix + acc_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
            MulFlags <= '0;
            count_q  <= '0;
            prod_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        sign_q   <= op_is_signed(op) & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        mcand_q  <= mag_a[WIDTH-1:0];
                        mplier_q <= mag_b[WIDTH-1:0];
                        acc_lo_q <= AccLo;
                        acc_hi_q <= AccHi;
                        prod_q   <= '0;
                        count_q  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    prod_q   <= prod_step;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    ResultLo <= result_c[WIDTH-1:0];
                    if (long_q_c) begin
                        ResultHi <= result_c[PW-1:WIDTH];
                        MulFlags <= {result_c[PW-1], (result_c == '0)};
                    end else begin
                        ResultHi <= '0;
                        MulFlags <= {result_c[WIDTH-1], (result_c[WIDTH-1:0] == '0)};
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_long_mul_unit.sv
// Self-checking bench for long_mul_unit at WIDTH=32 against an arithmetic reference model.
module tb_long_mul_unit;

    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] SrcA, SrcB, AccLo, AccHi;
    logic        busy, done;
    logic [31:0] ResultLo, ResultHi;
    logic [1:0]  MulFlags;

    int checks = 0;
    int errors = 0;

    long_mul_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .AccLo    (AccLo),
        .AccHi    (AccHi),
        .busy     (busy),
        .done     (done),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi),
        .MulFlags (MulFlags)
    );

    always #5 clk = ~clk;

    // Reference: full-precision arithmetic on the architectural operation.
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] alo, input logic [31:0] ahi,
                                   output logic [31:0] lo, output logic [31:0] hi, output logic [1:0] fl);
        logic [63:0] full;
        longint sa, sb;
        if (o == 3'b110 || o == 3'b111) begin
            sa = $signed(a);
            sb = $signed(b);
            full = 64'(sa * sb);
        end else begin
            full = {32'b0, a} * {32'b0, b};
        end
        if (o == 3'b101 || o == 3'b111) full = full + {ahi, alo};
        if (o == 3'b001) full = full + {32'b0, alo};
        if (o[2]) begin
            hi = full[63:32];
            lo = full[31:0];
            fl = {hi[31], (full == 64'd0)};
        end else begin
            hi = 32'd0;
            lo = full[31:0];
            fl = {lo[31], (lo == 32'd0)};
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Launches one operation from IDLE; optionally re-pulses start with new inputs at cycle glitch_at.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alo, input logic [31:0] ahi, input int glitch_at,
                         output logic [31:0] lo, output logic [31:0] hi, output logic [1:0] fl,
                         output int lat, output int busy_cyc, output logic done_after,
                         output logic busy_after);
        int k;
        op = o; SrcA = a; SrcB = b; AccLo = alo; AccHi = ahi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && k < TIMEOUT) begin
            if (busy === 1'b1) busy_cyc++;
            if (k == glitch_at) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 7));
                SrcA = $urandom; SrcB = $urandom; AccLo = $urandom; AccHi = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        lat = k;
        if (busy === 1'b1) busy_cyc++;
        lo = ResultLo; hi = ResultHi; fl = MulFlags;
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        start = 1'b0; op = 3'b000; SrcA = '0; SrcB = '0; AccLo = '0; AccHi = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if ({ResultHi, ResultLo} !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", {ResultHi, ResultLo}); end
        checks++; if (MulFlags !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", MulFlags); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] lo, hi; logic [1:0] fl; int lat, bc; logic da, ba;
        do_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo, fl} !== {32'd0, 32'd42, 2'b00}) begin errors++; $display("FAIL mul_7x6 got %h_%h fl=%b want 0_2a fl=00", hi, lo, fl); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
        checks++; if (bc !== 34) begin errors++; $display("FAIL mul_busy_cycles got %0d want 34", bc); end
        checks++; if ({da, ba} !== 2'b00) begin errors++; $display("FAIL done_single_pulse got done=%b busy=%b want 0 0", da, ba); end

        do_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo, fl[1]} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b1}) begin errors++; $display("FAIL umull_max got %h_%h N=%b want fffffffe_00000001 N=1", hi, lo, fl[1]); end

        do_op(3'b110, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo, fl} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB, 2'b10}) begin errors++; $display("FAIL smull_neg got %h_%h fl=%b want ffffffff_fffffffb fl=10", hi, lo, fl); end

        do_op(3'b111, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo} !== 64'h4000_0000_0000_0001) begin errors++; $display("FAIL smlal_minmin got %h_%h want 40000000_00000001", hi, lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] lo, hi; logic [1:0] fl; int lat, bc; logic da, ba;
        do_op(3'b001, 32'd0, 32'h1234, 32'd0, 32'd0, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo, fl} !== {32'd0, 32'd0, 2'b01}) begin errors++; $display("FAIL mla_zero got %h_%h fl=%b want 0_0 fl=01", hi, lo, fl); end
        do_op(3'b101, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd1, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo} !== {32'h0000_0002, 32'h0000_0005}) begin errors++; $display("FAIL b2b_umlal got %h_%h want 00000002_00000005", hi, lo); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] lo, hi, elo, ehi; logic [1:0] fl, efl; int lat, bc; logic da, ba;
        ref_op(3'b110, 32'hFFFF_FF9C, 32'd12345, 32'd0, 32'd0, elo, ehi, efl);
        do_op(3'b110, 32'hFFFF_FF9C, 32'd12345, 32'd0, 32'd0, 4, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo, fl} !== {ehi, elo, efl}) begin errors++; $display("FAIL start_ignored got %h_%h fl=%b want %h_%h fl=%b", hi, lo, fl, ehi, elo, efl); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL start_ignored_latency got %0d want 33", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] lo, hi; logic [1:0] fl; int lat, bc; logic da, ba;
        int seen_done;
        op = 3'b100; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1357_9BDF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({busy, done, seen_done != 0} !== 3'b000) begin errors++; $display("FAIL reset_mid_ctrl got busy=%b done=%b early_done=%0d want 0 0 0", busy, done, seen_done); end
        checks++; if ({ResultHi, ResultLo, MulFlags} !== 66'd0) begin errors++; $display("FAIL reset_mid_outputs got %h_%h fl=%b want 0", ResultHi, ResultLo, MulFlags); end
        do_op(3'b000, 32'd3, 32'd3, 32'd0, 32'd0, -1, lo, hi, fl, lat, bc, da, ba);
        checks++; if ({hi, lo, fl} !== {32'd0, 32'd9, 2'b00}) begin errors++; $display("FAIL after_reset_mul got %h_%h fl=%b want 0_9 fl=00", hi, lo, fl); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_reset_latency got %0d want 33", lat); end
    endtask

    task automatic test_random();
        logic [31:0] lo, hi, elo, ehi, a, b, alo, ahi; logic [1:0] fl, efl; logic [2:0] o;
        int lat, bc; logic da, ba;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand(); b = pick_operand(); alo = pick_operand(); ahi = pick_operand();
            ref_op(o, a, b, alo, ahi, elo, ehi, efl);
            do_op(o, a, b, alo, ahi, -1, lo, hi, fl, lat, bc, da, ba);
            checks++;
            if ({hi, lo, fl, lat} !== {ehi, elo, efl, 32'd33}) begin
                errors++;
                $display("FAIL random[%0d] op=%b a=%h b=%h acc=%h_%h got %h_%h fl=%b lat=%0d want %h_%h fl=%b lat=33",
                         i, o, a, b, ahi, alo, hi, lo, fl, lat, ehi, elo, efl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
